pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: PC, operand and stack-entry width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-003 SHALL have parameter KERNEL_ADDR, default 254: trap entry address.
REQ-004 SHALL have parameter RESET_ADDR, default 0: PC value after reset.
REQ-005 SHALL have ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_src  in  4  next-PC select.
- pc_write  in  1  PC update enable.
- stall  in  1  freezes all state.
- comp  in  1  branch-condition result.
- in_kernel  in  1  kernel-mode flag.
- ras_push  in  1  call marker: push the return address.
- imm_addr  in  WIDTH  absolute target.
- se_imm  in  WIDTH  sign-extended relative offset.
- ra  in  WIDTH  register target.
- mary  in  WIDTH  register operand.
- pc_out  out  WIDTH  current PC.
- epc_out  out  WIDTH  saved user PC.
- ras_top  out  WIDTH  top stack entry; 0 when empty.
- ras_empty  out  1  stack empty.
- ras_full  out  1  stack full.
- ras_ovf  out  1  sticky overflow flag.
- ras_unf  out  1  sticky underflow flag.

Function
REQ-006 SHALL select the next PC from pc_src, with all arithmetic modulo 2^WIDTH:
- 0000: pc+1.
- 0001: pc+se_imm.
- 0010: imm_addr.
- 0011: ra.
- 0100: mary.
- 0101: (mary<<4)+pc.
- 0110: imm_addr, conditional on comp.
- 0111: pc+se_imm, conditional on comp.
- 1000: KERNEL_ADDR.
- 1001: epc.
- 1010: RAS pop target.
- 1011-1111: hold.
REQ-007 SHALL define commit = pc_write & ~stall & ~(pc_src in {0110,0111} & ~comp).
REQ-008 SHALL load the selected next PC into pc_out on a commit edge and hold pc_out otherwise.
REQ-009 SHALL leave pc_out unchanged on a not-taken conditional; the pipeline re-issues pc+1 with 0000.
REQ-010 SHALL load epc from pc_out on every edge with in_kernel=0 and stall=0, and hold epc otherwise.
REQ-011 SHALL push (pc_out+1) onto the RAS on a commit edge with ras_push=1 and pc_src != 1010.
REQ-012 SHALL, on a push when the stack is full, discard the oldest entry (circular storage), keep the count at RAS_DEPTH and set ras_ovf.
REQ-013 SHALL, on a commit edge with pc_src=1010 and a non-empty stack, pop the stack, load pc_out with the old top and decrement the count.
REQ-014 SHALL, on a commit edge with pc_src=1010 and an empty stack, load pc_out with KERNEL_ADDR, leave the count at 0 and set ras_unf.
REQ-015 SHALL, on a commit edge with pc_src=1010, ras_push=1 and a non-empty stack, jump to the old top, replace the top with pc_out+1 and leave the count unchanged.
REQ-016 SHALL, on a commit edge with pc_src=1010, ras_push=1 and an empty stack, jump to KERNEL_ADDR, set ras_unf and push pc_out+1 (count becomes 1).
REQ-017 SHALL leave pc, RAS, flags and epc unchanged when stall=1, regardless of pc_write.
REQ-018 SHALL drive ras_empty=(count==0), ras_full=(count==RAS_DEPTH) and ras_top combinationally from registered state.
REQ-019 SHALL clear ras_ovf and ras_unf only by reset.
REQ-020 SHALL give one-cycle latency from a commit edge to pc_out, with no combinational path from any input to pc_out or epc_out.

Reset
REQ-021 SHALL, on a rising edge with reset=0, set pc_out=RESET_ADDR, epc_out=RESET_ADDR, RAS count 0, ras_top=0 and clear both flags; this overrides every other input, including during stall or mid-operation.
REQ-022 SHALL clear all outputs as in REQ-021 and resume normal operation on the first edge after reset returns to 1.

Verification
REQ-023 SHALL cover sequencing and relative jump:
- reset, then pc_src=0000, pc_write=1 for 3 cycles -> pc_out 0,1,2,3.
- then pc_src=0001, se_imm=0xFFFE -> pc_out=1.
REQ-024 SHALL cover a not-taken conditional: pc=5, pc_src=0111, comp=0, pc_write=1 -> pc_out stays 5; with comp=1 and se_imm=3 -> 8.
REQ-025 SHALL cover call/return: pc=0x10, imm_addr=0x40, pc_src=0010, ras_push=1 -> pc=0x40, ras_top=0x11; then pc_src=1010 -> pc=0x11, ras_empty=1.
REQ-026 SHALL cover overflow: 5 pushes (RAS_DEPTH=4) of return addresses 1..5 -> ras_full=1, ras_ovf=1; 4 pops return 5,4,3,2; a 5th pop -> pc=254, ras_unf=1.
REQ-027 SHALL cover trap and trap return: in_kernel=0 at pc=0x22, pc_src=1000 -> pc=254; then in_kernel=1 for 3 cycles -> epc_out=0x22; pc_src=1001 -> pc=0x22.
REQ-028 SHALL cover stall and reset priority: stall=1 with pc_src=0010 and pc_write=1 -> no state change; reset=0 during stall with a non-empty stack -> pc=0, ras_empty=1, flags 0.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Control, operand and status bundle between the pipeline front end and pc_sequencer.
// The master drives the selects and operands; the slave returns PC, EPC and return-stack status.
interface pc_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       pc_src;
  logic             pc_write;
  logic             stall;
  logic             comp;
  logic             in_kernel;
  logic             ras_push;
  logic [WIDTH-1:0] imm_addr;
  logic [WIDTH-1:0] se_imm;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] mary;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] epc_out;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output pc_src, pc_write, stall, comp, in_kernel, ras_push,
           imm_addr, se_imm, ra, mary,
    input  pc_out, epc_out, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  pc_src, pc_write, stall, comp, in_kernel, ras_push,
           imm_addr, se_imm, ra, mary,
    output pc_out, epc_out, ras_top, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: next-PC selection, trap EPC capture and a circular
// return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int WIDTH       = 16,
  parameter int RAS_DEPTH   = 4,
  parameter int KERNEL_ADDR = 254,
  parameter int RESET_ADDR  = 0
) (
  input  logic           clock,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] KernelPc = WIDTH'(KERNEL_ADDR);
  localparam logic [WIDTH-1:0] ResetPc  = WIDTH'(RESET_ADDR);
  localparam logic [CNT_W-1:0] FullCnt  = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, epc_q;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q, unf_q;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ret_addr;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;
  logic             empty, full, is_cond, is_ret, commit, do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign ret_addr = pc_q + WIDTH'(1);
  assign ptr_inc  = ptr_q + PTR_W'(1);
  assign ptr_dec  = ptr_q - PTR_W'(1);
  assign is_cond  = (bus.pc_src == 4'b0110) || (bus.pc_src == 4'b0111);
  assign is_ret   = (bus.pc_src == 4'b1010);
  assign commit   = bus.pc_write & ~bus.stall & ~(is_cond & ~bus.comp);
  assign do_push  = commit & bus.ras_push & ~is_ret;
  assign do_pop   = commit & is_ret;

  always_comb begin
    pc_d = pc_q;
    case (bus.pc_src)
      4'b0000: pc_d = pc_q + WIDTH'(1);
      4'b0001: pc_d = pc_q + bus.se_imm;
      4'b0010: pc_d = bus.imm_addr;
      4'b0011: pc_d = bus.ra;
      4'b0100: pc_d = bus.mary;
      4'b0101: pc_d = (bus.mary << 4) + pc_q;
      4'b0110: pc_d = bus.imm_addr;
      4'b0111: pc_d = pc_q + bus.se_imm;
      4'b1000: pc_d = KernelPc;
      4'b1001: pc_d = epc_q;
      4'b1010: pc_d = empty ? KernelPc : stack_q[ptr_q];
      default: pc_d = pc_q;
    endcase
  end

  // A return combined with a call reuses the top slot; the stack pointer always
  // names the live top entry and wraps, so a full push silently drops the oldest.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q    <= ResetPc;
      epc_q   <= ResetPc;
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!bus.stall) begin
      if (!bus.in_kernel) epc_q <= pc_q;
      if (commit)         pc_q  <= pc_d;
      if (do_push) begin
        ptr_q            <= ptr_inc;
        stack_q[ptr_inc] <= ret_addr;
        if (full) ovf_q   <= 1'b1;
        else      count_q <= count_q + CNT_W'(1);
      end else if (do_pop) begin
        if (empty) begin
          unf_q <= 1'b1;
          if (bus.ras_push) begin
            ptr_q            <= ptr_inc;
            stack_q[ptr_inc] <= ret_addr;
            count_q          <= CNT_W'(1);
          end
        end else if (bus.ras_push) begin
          stack_q[ptr_q] <= ret_addr;
        end else begin
          ptr_q   <= ptr_dec;
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.epc_out   = epc_q;
  assign bus.ras_top   = empty ? '0 : stack_q[ptr_q];
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a queue-based reference model of PC, EPC and return stack.
module tb_pc_sequencer;

  localparam int Width     = 16;
  localparam int RasDepth  = 4;
  localparam int KernelPc  = 254;
  localparam int ResetPc   = 0;

  logic clock;
  logic reset;
  int   checkCount;
  int   failCount;

  pc_sequencer_if #(.WIDTH(Width)) bus ();

  pc_sequencer #(
    .WIDTH(Width), .RAS_DEPTH(RasDepth), .KERNEL_ADDR(KernelPc), .RESET_ADDR(ResetPc)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: the return stack is a plain queue, newest entry at the back.
  logic [Width-1:0] modelPc;
  logic [Width-1:0] modelEpc;
  logic [Width-1:0] modelStack[$];
  logic             modelOvf;
  logic             modelUnf;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic updateModel(input logic rstN, input logic [3:0] src, input logic pw,
                             input logic st, input logic cp, input logic ik,
                             input logic push, input logic [Width-1:0] imm,
                             input logic [Width-1:0] se, input logic [Width-1:0] raV,
                             input logic [Width-1:0] maryV);
    logic [Width-1:0] oldPc;
    logic [Width-1:0] target;
    logic             taken;
    if (!rstN) begin
      modelPc  = Width'(ResetPc);
      modelEpc = Width'(ResetPc);
      modelStack.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
      return;
    end
    if (st) return;
    oldPc = modelPc;
    if (!ik) modelEpc = oldPc;
    taken = pw && !((src == 4'd6 || src == 4'd7) && !cp);
    if (!taken) return;
    target = oldPc;
    case (src)
      4'd0:  target = oldPc + 1;
      4'd1:  target = oldPc + se;
      4'd2:  target = imm;
      4'd3:  target = raV;
      4'd4:  target = maryV;
      4'd5:  target = maryV * 16 + oldPc;
      4'd6:  target = imm;
      4'd7:  target = oldPc + se;
      4'd8:  target = Width'(KernelPc);
      4'd9:  target = modelEpc == oldPc && !ik ? oldPc : target;
      4'd10: begin
        if (modelStack.size() == 0) begin
          target   = Width'(KernelPc);
          modelUnf = 1'b1;
        end else begin
          target = modelStack.pop_back();
        end
        if (push) modelStack.push_back(oldPc + 1);
      end
      default: target = oldPc;
    endcase
    modelPc = target;
    if (push && src != 4'd10) begin
      modelStack.push_back(oldPc + 1);
      if (modelStack.size() > RasDepth) begin
        void'(modelStack.pop_front());
        modelOvf = 1'b1;
      end
    end
  endtask

  // The EPC-return target must be the EPC held before this edge, so it is
  // resolved separately from the generic case above.
  logic [Width-1:0] epcBeforeEdge;

  task automatic applyStimulus(input logic rstN, input logic [3:0] src, input logic pw,
                               input logic st, input logic cp, input logic ik,
                               input logic push, input logic [Width-1:0] imm,
                               input logic [Width-1:0] se, input logic [Width-1:0] raV,
                               input logic [Width-1:0] maryV);
    logic [Width-1:0] expTop;
    reset         = rstN;
    bus.pc_src    = src;
    bus.pc_write  = pw;
    bus.stall     = st;
    bus.comp      = cp;
    bus.in_kernel = ik;
    bus.ras_push  = push;
    bus.imm_addr  = imm;
    bus.se_imm    = se;
    bus.ra        = raV;
    bus.mary      = maryV;
    epcBeforeEdge = modelEpc;
    updateModel(rstN, src, pw, st, cp, ik, push, imm, se, raV, maryV);
    if (rstN && !st && pw && src == 4'd9) modelPc = epcBeforeEdge;
    @(posedge clock);
    #1;
    expTop = (modelStack.size() == 0) ? '0 : modelStack[modelStack.size() - 1];
    checkOutput("pc_out",    32'(bus.pc_out),    32'(modelPc));
    checkOutput("epc_out",   32'(bus.epc_out),   32'(modelEpc));
    checkOutput("ras_top",   32'(bus.ras_top),   32'(expTop));
    checkOutput("ras_empty", 32'(bus.ras_empty), 32'(modelStack.size() == 0));
    checkOutput("ras_full",  32'(bus.ras_full),  32'(modelStack.size() == RasDepth));
    checkOutput("ras_ovf",   32'(bus.ras_ovf),   32'(modelOvf));
    checkOutput("ras_unf",   32'(bus.ras_unf),   32'(modelUnf));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic jumpTo(input logic [Width-1:0] addr, input logic push);
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, push, addr, '0, '0, '0);
  endtask

  task automatic runSrc(input logic [3:0] src, input logic ik, input logic push,
                        input logic cp, input logic [Width-1:0] se);
    applyStimulus(1'b1, src, 1'b1, 1'b0, cp, ik, push, '0, se, '0, '0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    modelPc    = '0;
    modelEpc   = '0;
    modelOvf   = 1'b0;
    modelUnf   = 1'b0;
    reset      = 1'b0;
    bus.pc_src = '0; bus.pc_write = 1'b0; bus.stall = 1'b0; bus.comp = 1'b0;
    bus.in_kernel = 1'b0; bus.ras_push = 1'b0;
    bus.imm_addr = '0; bus.se_imm = '0; bus.ra = '0; bus.mary = '0;

    // Sequencing and relative jump back by two.
    doReset();
    checkOutput("reset_pc", 32'(bus.pc_out), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      runSrc(4'd0, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("seq_pc", 32'(bus.pc_out), 32'(i));
    end
    runSrc(4'd1, 1'b0, 1'b0, 1'b0, 16'hFFFE);
    checkOutput("rel_pc", 32'(bus.pc_out), 32'd1);

    // Conditional relative branch, not taken then taken.
    jumpTo(16'd5, 1'b0);
    runSrc(4'd7, 1'b0, 1'b0, 1'b0, 16'd3);
    checkOutput("nottaken_pc", 32'(bus.pc_out), 32'd5);
    runSrc(4'd7, 1'b0, 1'b0, 1'b1, 16'd3);
    checkOutput("taken_pc", 32'(bus.pc_out), 32'd8);

    // Call and return.
    jumpTo(16'h10, 1'b0);
    jumpTo(16'h40, 1'b1);
    checkOutput("call_pc", 32'(bus.pc_out), 32'h40);
    checkOutput("call_top", 32'(bus.ras_top), 32'h11);
    runSrc(4'd10, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("ret_pc", 32'(bus.pc_out), 32'h11);
    checkOutput("ret_empty", 32'(bus.ras_empty), 32'd1);

    // Overflow: five pushes of 1..5, four pops, then an underflowing pop.
    doReset();
    for (int i = 0; i < 5; i++) runSrc(4'd0, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("ovf_full", 32'(bus.ras_full), 32'd1);
    checkOutput("ovf_flag", 32'(bus.ras_ovf), 32'd1);
    for (int i = 5; i >= 2; i--) begin
      runSrc(4'd10, 1'b0, 1'b0, 1'b0, '0);
      checkOutput("pop_pc", 32'(bus.pc_out), 32'(i));
    end
    runSrc(4'd10, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("unf_pc", 32'(bus.pc_out), 32'd254);
    checkOutput("unf_flag", 32'(bus.ras_unf), 32'd1);

    // Trap entry, kernel residency, trap return.
    doReset();
    jumpTo(16'h22, 1'b0);
    runSrc(4'd8, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("trap_pc", 32'(bus.pc_out), 32'd254);
    for (int i = 0; i < 3; i++) runSrc(4'd11, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("trap_epc", 32'(bus.epc_out), 32'h22);
    runSrc(4'd9, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("eret_pc", 32'(bus.pc_out), 32'h22);

    // Stall freezes everything; reset wins over stall.
    doReset();
    runSrc(4'd10, 1'b0, 1'b0, 1'b0, '0);
    jumpTo(16'h30, 1'b1);
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h99, '0, '0, '0);
    checkOutput("stall_pc", 32'(bus.pc_out), 32'h30);
    applyStimulus(1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h99, '0, '0, '0);
    checkOutput("rststall_pc", 32'(bus.pc_out), 32'd0);
    checkOutput("rststall_empty", 32'(bus.ras_empty), 32'd1);
    checkOutput("rststall_unf", 32'(bus.ras_unf), 32'd0);

    // Random traffic, biased toward commits and stack activity.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 7) == 0),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 1) == 0),
                    16'($urandom), 16'($urandom_range(0, 15) - 8),
                    16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
